// File: rtl/dl_access_ctrl.sv
// ---------------------------------------------------------------------------
// dl_access_ctrl
//
// Serial access and recirculation controller for one delay-line memory.
// Sits in front of the delay-line driver gate and consumes the sense-amp
// bit. Every bit time (bit_en_i strobe) the sensed bit is either
// recirculated back into the line or replaced by a bit of a pending write.
// Independently, one addressed word can be deserialized for a read.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   bit_en_i          one-cycle strobe marking a bit time
//   sync_i            with bit_en_i: this bit time is bit 0 of word 0
//   sa_in_i           sense-amp bit, valid with bit_en_i
//   dl_out_o          registered bit to the delay-line driver gate
//   locked_o          position counters aligned to sync_i
//   sync_err_o        one-cycle pulse: sync_i seen at an unexpected position
//   wr_req_i/addr/data   write request (held by requester until wr_busy_o)
//   wr_busy_o/wr_ack_o   write in flight / one-cycle commit pulse
//   rd_req_i/addr     read request
//   rd_data_o         last word read, held until the next read completes
//   rd_valid_o        one-cycle pulse: rd_data_o updated
//   rd_perr_o         parity error, qualified by rd_valid_o
//
// Optional build macro
//   DL_PARITY_EN      writes replace the MSB with odd parity of the lower
//                     bits; reads flag rd_perr_o when the captured word has
//                     even parity. Undefined: words stored verbatim and
//                     rd_perr_o is tied low.
//
// Words are serial LSB first. WORD_BITS must be at least 2. An address
// >= WORDS is accepted but never matches, so that FSM waits until reset.
// ---------------------------------------------------------------------------
module dl_access_ctrl #(
    parameter int WORD_BITS = 28,
    parameter int WORDS     = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bit_en_i,
    input  logic                 sync_i,
    input  logic                 sa_in_i,
    output logic                 dl_out_o,
    output logic                 locked_o,
    output logic                 sync_err_o,
    input  logic                 wr_req_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [WORD_BITS-1:0] wr_data_i,
    output logic                 wr_busy_o,
    output logic                 wr_ack_o,
    input  logic                 rd_req_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [WORD_BITS-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 rd_perr_o
);

    localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_BITS - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_SHIFT}   wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_CAPTURE} rd_state_e;

    // -----------------------------------------------------------------------
    // Position tracking
    // -----------------------------------------------------------------------
    // bit_cnt_q/word_cnt_q hold the position of the *next* bit time.
    // cur_bit/cur_word are the position of the bit time being processed;
    // sync_i overrides it to 0/0.
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d,  cur_bit;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d, cur_word;
    logic              locked_q;
    logic              sync_err_q;
    logic              resync;

    always_comb begin
        cur_bit  = sync_i ? '0 : bit_cnt_q;
        cur_word = sync_i ? '0 : word_cnt_q;
        // A SYNC that lands where the counters were not already at 0/0
        // means the line slipped: flag it and abort any word in progress.
        resync   = bit_en_i && sync_i && locked_q &&
                   ((bit_cnt_q != '0) || (word_cnt_q != '0));

        bit_cnt_d  = cur_bit + BIT_W'(1);
        word_cnt_d = cur_word;
        if (cur_bit == LAST_BIT) begin
            bit_cnt_d  = '0;
            word_cnt_d = (cur_word == LAST_WORD) ? '0 : cur_word + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= resync;
            if (bit_en_i) begin
                bit_cnt_q  <= bit_cnt_d;
                word_cnt_q <= word_cnt_d;
                if (sync_i) begin
                    locked_q <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    wr_state_e              wr_state_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [WORD_BITS-1:0]   wr_data_q, wr_data_d;
    logic                   wr_busy_q, wr_ack_q;
    logic                   wr_match, wr_drive;

    always_comb begin
        wr_data_d = wr_data_i;
`ifdef DL_PARITY_EN
        // Odd parity over the payload bits takes the MSB slot.
        wr_data_d[WORD_BITS-1] = ~(^wr_data_i[WORD_BITS-2:0]);
`endif
    end

    // Start of the addressed word. A resync bit time never starts a word.
    assign wr_match = bit_en_i && !resync && (cur_bit == '0) &&
                      (cur_word == wr_addr_q);

    // Bit 0 is substituted on the very bit time that matches, so the
    // whole word (bits 0..WORD_BITS-1) is replaced within one pass.
    assign wr_drive = ((wr_state_q == W_WAIT) && wr_match) ||
                      ((wr_state_q == W_SHIFT) && !resync);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_busy_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            unique case (wr_state_q)
                W_IDLE: begin
                    if (wr_req_i && locked_q) begin
                        wr_addr_q  <= wr_addr_i;
                        wr_data_q  <= wr_data_d;
                        wr_busy_q  <= 1'b1;
                        wr_state_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wr_match) begin
                        wr_state_q <= W_SHIFT;
                    end
                end
                W_SHIFT: begin
                    if (bit_en_i) begin
                        if (resync) begin
                            // Request stays latched; retried on the next pass.
                            wr_state_q <= W_WAIT;
                        end else if (cur_bit == LAST_BIT) begin
                            wr_ack_q   <= 1'b1;
                            wr_busy_q  <= 1'b0;
                            wr_state_q <= W_IDLE;
                        end
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Line driver
    // -----------------------------------------------------------------------
    logic dl_out_q, dl_out_d;

    assign dl_out_d = wr_drive ? wr_data_q[cur_bit] : sa_in_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dl_out_q <= 1'b0;
        end else if (bit_en_i) begin
            dl_out_q <= dl_out_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    rd_state_e              rd_state_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    // Holds bits 0..WORD_BITS-2 as they arrive; shifting in at the MSB
    // leaves bit 0 at the LSB once WORD_BITS-1 bits are in.
    logic [WORD_BITS-2:0]   rd_shift_q;
    logic [WORD_BITS-1:0]   rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_perr_q, rd_perr_d;
    logic                   rd_match;

    assign rd_match = bit_en_i && !resync && (cur_bit == '0) &&
                      (cur_word == rd_addr_q);

    // Final word: the last bit comes straight from the sense amp.
    always_comb begin
        rd_data_d = {sa_in_i, rd_shift_q};
`ifdef DL_PARITY_EN
        rd_perr_d = ~(^rd_data_d);
`else
        rd_perr_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_shift_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_perr_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (rd_state_q)
                R_IDLE: begin
                    if (rd_req_i && locked_q) begin
                        rd_addr_q  <= rd_addr_i;
                        rd_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rd_match) begin
                        rd_shift_q <= {sa_in_i, rd_shift_q[WORD_BITS-2:1]};
                        rd_state_q <= R_CAPTURE;
                    end
                end
                R_CAPTURE: begin
                    if (bit_en_i) begin
                        if (resync) begin
                            rd_state_q <= R_WAIT;
                        end else if (cur_bit == LAST_BIT) begin
                            rd_data_q  <= rd_data_d;
                            rd_perr_q  <= rd_perr_d;
                            rd_valid_q <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_shift_q <= {sa_in_i, rd_shift_q[WORD_BITS-2:1]};
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign dl_out_o   = dl_out_q;
    assign locked_o   = locked_q;
    assign sync_err_o = sync_err_q;
    assign wr_busy_o  = wr_busy_q;
    assign wr_ack_o   = wr_ack_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_perr_o  = rd_perr_q;

endmodule

// File: tb/tb_dl_access_ctrl.sv
module tb_dl_access_ctrl;
  localparam int WB = 8, NW = 4, AW = 2, LINE = WB * NW;
  localparam int DRAIN = 2 * LINE * 4 + 40;

  logic clk = 1'b0, rst = 1'b1;
  logic bit_en = 1'b0, sync = 1'b0, sa_in = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [WB-1:0] wr_data = '0;
  logic dl_out, locked, sync_err, wr_busy, wr_ack, rd_valid, rd_perr;
  logic [WB-1:0] rd_data;

  always #5 clk = ~clk;

  dl_access_ctrl #(.WORD_BITS(WB), .WORDS(NW), .ADDR_W(AW)) u_dut (
    .clk_i(clk), .rst_i(rst), .bit_en_i(bit_en), .sync_i(sync), .sa_in_i(sa_in),
    .dl_out_o(dl_out), .locked_o(locked), .sync_err_o(sync_err),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_busy_o(wr_busy), .wr_ack_o(wr_ack),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .rd_perr_o(rd_perr)
  );

  typedef struct packed { logic [WB-1:0] data; logic perr; } rd_exp_t;
  rd_exp_t       rd_q[$];
  logic [AW-1:0] wr_q[$];

  int n_chk = 0, n_err = 0, n_serr = 0, n_ack = 0, n_vld = 0;

  // delay-line model: slot ptr is the bit time in flight
  logic dl_model [LINE];
  int   ptr = 0, base = 0, sync_at = 0;
  bit   sync_arm = 1'b0, preload = 1'b0;
  logic [WB-1:0] pre_w [NW] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] enc(input logic [WB-1:0] d);
    logic [WB-1:0] r;
    r = d;
`ifdef DL_PARITY_EN
    r[WB-1] = ~(^d[WB-2:0]);
`endif
    return r;
  endfunction

  function automatic logic exp_perr(input logic [WB-1:0] d);
`ifdef DL_PARITY_EN
    return ~(^d);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [WB-1:0] mword(input int w);
    logic [WB-1:0] r;
    for (int b = 0; b < WB; b++) r[b] = dl_model[(base + w * WB + b) % LINE];
    return r;
  endfunction

  // line driver: BIT_EN every 4th clock, SA_IN from the model, DL_OUT written back
  initial begin
    int phase;
    phase = 0;
    for (int i = 0; i < LINE; i++) dl_model[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (bit_en) begin
        dl_model[ptr] = dl_out;
        ptr = (ptr + 1) % LINE;
      end
      if (preload) begin
        for (int w = 0; w < NW; w++)
          for (int b = 0; b < WB; b++) dl_model[w * WB + b] = pre_w[w][b];
        preload = 1'b0;
      end
      bit_en = 1'b0;
      sync   = 1'b0;
      phase  = (phase + 1) % 4;
      if (phase == 0) begin
        bit_en = 1'b1;
        sa_in  = dl_model[ptr];
        if (sync_arm && ptr == sync_at) begin
          sync     = 1'b1;
          sync_arm = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (sync_err) n_serr++;
      if (rd_valid) begin
        rd_exp_t e;
        n_vld++;
        chk("rd_pending", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e.data));
          chk("rd_perr", 32'(rd_perr), 32'(e.perr));
        end
      end
      if (wr_ack) begin
        n_ack++;
        chk("wr_ack_pending", 32'(wr_q.size() != 0), 32'd1);
        chk("wr_busy_at_ack", 32'(wr_busy), 32'd0);
        if (wr_q.size() != 0) void'(wr_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [AW-1:0] a, input logic [WB-1:0] d);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    wr_q.push_back(a);
    tick(1);
    wr_req = 1'b0;
    chk("wr_busy_next", 32'(wr_busy), 32'd1);
  endtask

  task automatic issue_rd(input logic [AW-1:0] a, input logic [WB-1:0] d);
    rd_exp_t e;
    e.data = d; e.perr = exp_perr(d);
    rd_q.push_back(e);
    rd_addr = a; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && n < DRAIN) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, 32'(rd_q.size() == 0 && wr_q.size() == 0), 32'd1);
  endtask

  task automatic wait_ptr(input int target);
    int n;
    n = 0;
    while (ptr != target && n < 400) begin
      tick(1);
      n++;
    end
    chk("ptr_timeout", 32'(ptr), 32'(target));
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (!locked && n < 400) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(locked), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_before, n;
    // reset state
    tick(4);
    chk("rst_outs", 32'({dl_out, locked, sync_err, wr_busy, wr_ack, rd_valid, rd_perr}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    preload = 1'b1;
    tick(8);
    chk("unlocked", 32'(locked), 32'd0);
    wr_addr = 2'd0; wr_data = 8'h11; wr_req = 1'b1;
    tick(3);
    chk("wr_ignored_unlocked", 32'(wr_busy), 32'd0);
    wr_req = 1'b0;

    // lock and recirculate
    base = 0; sync_at = 0; sync_arm = 1'b1;
    wait_lock("lock");
    tick(3 * LINE * 4);
    chk("no_sync_err", 32'(n_serr), 32'd0);
    for (int w = 0; w < NW; w++) chk("recirc_word", 32'(mword(w)), 32'(pre_w[w]));

    // write then read back
    issue_wr(2'd2, 8'h5A);
    wait_drain("wr_drain");
    issue_rd(2'd2, enc(8'h5A));
    wait_drain("rd_drain");
    chk("rd_valid_once", 32'(n_vld), 32'd1);
    chk("word2_model", 32'(mword(2)), 32'(enc(8'h5A)));
    chk("word0_kept", 32'(mword(0)), 32'h A5);
    chk("word1_kept", 32'(mword(1)), 32'h3C);
    chk("word3_kept", 32'(mword(3)), 32'h01);

    // same-word collision: read sees the previous pass
    begin
      rd_exp_t e;
      e.data = 8'h3C; e.perr = exp_perr(8'h3C);
      rd_q.push_back(e);
      wr_q.push_back(2'd1);
      wr_addr = 2'd1; wr_data = 8'h77; rd_addr = 2'd1;
      wr_req = 1'b1; rd_req = 1'b1;
      tick(1);
      wr_req = 1'b0; rd_req = 1'b0;
      chk("coll_wr_busy", 32'(wr_busy), 32'd1);
    end
    wait_drain("coll_drain");
    issue_rd(2'd1, enc(8'h77));
    wait_drain("coll_rd2_drain");

    // resync in the middle of shifting word 1
    wait_ptr((base + 1) % LINE);
    issue_wr(2'd1, 8'hC3);
    acks_before = n_ack;
    sync_at = (base + 11) % LINE; sync_arm = 1'b1;
    n = 0;
    while (!sync_err && n < 400) begin
      tick(1);
      n++;
    end
    chk("sync_err_pulse", 32'(sync_err), 32'd1);
    chk("no_ack_before_resync", 32'(n_ack), 32'(acks_before));
    chk("busy_after_resync", 32'(wr_busy), 32'd1);
    base = sync_at;
    tick(1);
    chk("sync_err_one_cycle", 32'(sync_err), 32'd0);
    wait_drain("resync_wr_drain");
    chk("ack_after_resync", 32'(n_ack), 32'(acks_before + 1));
    issue_rd(2'd1, enc(8'hC3));
    wait_drain("resync_rd_drain");

    // reset in the middle of a shift
    wait_ptr((base + 16) % LINE);
    issue_wr(2'd0, 8'h99);
    wait_ptr((base + 3) % LINE);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_shift", 32'({wr_busy, wr_ack, dl_out, locked}), 32'd0);
    rst = 1'b0;
    wr_q.delete();
    wr_addr = 2'd0; wr_data = 8'h42; wr_req = 1'b1;
    tick(3);
    chk("wr_ignored_after_rst", 32'(wr_busy), 32'd0);
    wr_req = 1'b0;
    sync_at = 5; base = 5; sync_arm = 1'b1;
    wait_lock("relock");
    issue_wr(2'd3, 8'h3C);
    wait_drain("relock_wr_drain");
    issue_rd(2'd3, enc(8'h3C));
    wait_drain("relock_rd_drain");

`ifdef DL_PARITY_EN
    issue_wr(2'd2, 8'h03);
    wait_drain("par_wr_drain");
    chk("par_stored", 32'(mword(2)), 32'h83);
    wait_ptr((base + 8) % LINE);
    dl_model[(base + 2 * WB) % LINE] = ~dl_model[(base + 2 * WB) % LINE];
    issue_rd(2'd2, 8'h82);
    wait_drain("par_rd_drain");
    chk("par_perr_seen", 32'(rd_perr), 32'd1);
`endif

    chk("total_sync_err", 32'(n_serr), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dl_access_ctrl.md
Name: dl_access_ctrl

Overview:
Serial access and recirculation controller for one delay-line memory. It sits directly upstream of the delay-line driver, feeding its gate input, and consumes the sense-amplifier output. Each bit time it either recirculates the sensed bit back into the line or substitutes a bit from a pending write. It also deserializes one addressed word for reads. One instance serves each line (44-line, 31-line).

Parameters:
WORD_BITS, 28, bits per stored word (serial, LSB first)
WORDS, 4, words per line revolution
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= WORDS

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST  in  1  synchronous, active-high reset
BIT_EN  in  1  one-cycle strobe marking a bit time
SYNC  in  1  sampled with BIT_EN; marks bit 0 of word 0
SA_IN  in  1  sense-amp bit, valid when BIT_EN
DL_OUT  out  1  registered driver bit to the delay-line driver gate
LOCKED  out  1  counters aligned to SYNC
SYNC_ERR  out  1  one-cycle pulse: SYNC arrived at an unexpected position
WR_REQ  in  1  write request
WR_ADDR  in  ADDR_W  write word address
WR_DATA  in  WORD_BITS  write word
WR_BUSY  out  1  write accepted and not yet acknowledged
WR_ACK  out  1  one-cycle pulse: write committed to the line
RD_REQ  in  1  read request
RD_ADDR  in  ADDR_W  read word address
RD_DATA  out  WORD_BITS  last word read; held until the next read completes
RD_VALID  out  1  one-cycle pulse: RD_DATA updated
RD_PERR  out  1  parity error flag, qualified by RD_VALID

Behaviour:
- Reset: all outputs 0, counters 0, both FSMs IDLE, LOCKED=0. DL_OUT=0 during reset, so line contents are lost; this is intended.
- Position counters advance only on BIT_EN:
  - BIT_CNT counts 0..WORD_BITS-1 and wraps to 0.
  - On that wrap, WORD_CNT increments through 0..WORDS-1 and wraps.
- SYNC with BIT_EN forces BIT_CNT=0, WORD_CNT=0 for that bit time.
  - If LOCKED=0: set LOCKED=1.
  - If LOCKED=1 and the counters would not already have been 0/0: pulse SYNC_ERR the next cycle and abort any WAIT/SHIFT or WAIT/CAPTURE operation back to WAIT. No ACK or VALID is issued; the request stays latched.
- DL_OUT is updated only on BIT_EN cycles:
  - write FSM in SHIFT: DL_OUT = latched write bit [BIT_CNT]
  - otherwise: DL_OUT = SA_IN (recirculate)
- Write FSM, states IDLE, WAIT, SHIFT:
  - IDLE: WR_REQ accepted when LOCKED=1. Latch WR_ADDR and WR_DATA; WR_BUSY=1 the next cycle; go to WAIT. WR_REQ while busy or unlocked is ignored; the requester holds it.
  - WAIT to SHIFT: on the BIT_EN where BIT_CNT=0 and WORD_CNT equals the latched address.
  - SHIFT: lasts exactly WORD_BITS bit times. After the last bit's BIT_EN: WR_ACK pulses one cycle, WR_BUSY drops in the same cycle, go to IDLE.
- Read FSM, states IDLE, WAIT, CAPTURE, runs independently of the write FSM:
  - Acceptance and address match are the same as for writes.
  - CAPTURE shifts SA_IN into RD_DATA[BIT_CNT] across WORD_BITS bit times.
  - Then RD_VALID pulses one cycle and the FSM returns to IDLE.
- Read and write of the same word in the same revolution: the read returns the old contents, because SA_IN carries the previous pass.
- An out-of-range address (>= WORDS) is accepted and never matches. The FSM stays in WAIT until RST; this is a documented hazard.
- Line timing contract: the bit driven on DL_OUT at bit time k is presented on SA_IN at bit time k + WORDS*WORD_BITS.
- Maximum latency, request to ACK/VALID: 2*WORDS*WORD_BITS bit times plus 2 cycles.

Optional Feature:
DL_PARITY_EN
- Defined:
  - On write, WR_DATA[WORD_BITS-1] is ignored and replaced by odd parity of WR_DATA[WORD_BITS-2:0].
  - On read, RD_PERR=1 with RD_VALID when the XOR of all WORD_BITS captured bits is 0.
- Undefined: all WORD_BITS bits are stored verbatim and RD_PERR is tied 0.

Test Plan:
All scenarios use WORD_BITS=8, WORDS=4, BIT_EN every 4th CLK, and a bench delay-line model of 32 bit times.
- Lock and recirculate: preload the model with 0xA5,0x3C,0xFF,0x01 and apply SYNC -> LOCKED=1. After 3 revolutions the model contents are unchanged and SYNC_ERR stays 0.
- Write: WR_REQ, addr 2, data 0x5A -> WR_BUSY next cycle, WR_ACK after word 2 is shifted. The next read of addr 2 gives RD_DATA=0x5A, RD_VALID once; words 0, 1, 3 are unchanged.
- Same-word collision: write 0x77 and read addr 1 in the same cycle, old value 0x3C -> read returns 0x3C; a following read returns 0x77.
- Resync: SYNC asserted at WORD_CNT=1, BIT_CNT=3 during a pending write -> SYNC_ERR pulse, no WR_ACK that revolution, WR_ACK on the next revolution, data correct.
- Reset mid-SHIFT -> WR_BUSY, WR_ACK, DL_OUT, LOCKED all 0 the next cycle; a new request is ignored until SYNC.
- DL_PARITY_EN: write 0x03 -> stored 0x83. Corrupt one bit in the model -> the read gives RD_PERR=1 with RD_VALID.
